cipher_seq_ctrl: RTL

Interface sequencer for the stream cipher datapath. It takes user byte strobes, loads key material into the keystream engine, launches one encryption per plaintext byte and waits for the engine's done pulse. It then holds the interface state until the user acknowledges the read, which lets the output holder clear. Sits between the chip pins, the encryption block and the output holder; its state output is the interface state that the output holder consumes.

---
 rtl/cipher_seq_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/cipher_seq_ctrl.sv
// cipher_seq_ctrl -- interface sequencer for the stream cipher datapath.
// Turns user byte strobes into key writes or encryption launches, waits for
// the engine's done pulse, and holds the interface state until the user
// acknowledges the read.
// Optional build macro: OVERRUN_DETECT_EN adds a sticky 'overrun' output that
// flags user bytes dropped while the sequencer was not idle.
module cipher_seq_ctrl #(
   parameter int KEY_BYTES      = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                         clk,
   input  logic                         nrst,
   input  logic                         in_valid,
   input  logic [7:0]                   in_byte,
   input  logic                         key_mode,
   input  logic                         read_ack,
   input  logic                         enc_done,
   input  logic                         holder_ready,
   output logic                         key_we,
   output logic [$clog2(KEY_BYTES)-1:0] key_idx,
   output logic [7:0]                   key_byte,
   output logic                         enc_start,
   output logic [7:0]                   enc_byte,
   output logic [2:0]                   state,
   output logic                         out_valid,
   output logic                         busy,
`ifdef OVERRUN_DETECT_EN
   output logic                         overrun,
`endif
   output logic                         err
);

   localparam int IDX_W = $clog2(KEY_BYTES);

   // Interface state encoding is visible to the output holder; 1 is reserved.
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_ENCRYPT   = 3'd2;
   localparam logic [2:0] ST_WAIT_READ = 3'd3;
   localparam logic [2:0] ST_ERROR     = 3'd4;

   localparam logic [IDX_W-1:0] KEY_LAST = IDX_W'(KEY_BYTES - 1);
   localparam logic [7:0]       TO_LAST  = 8'(TIMEOUT_CYCLES - 1);

   logic [2:0]       r_state;
   logic             r_inValidQ;
   logic             r_readAckQ;
   logic             r_keyWe;
   logic [IDX_W-1:0] r_keyIdx;
   logic [7:0]       r_keyByte;
   logic             r_encStart;
   logic [7:0]       r_encByte;
   logic [IDX_W-1:0] r_keyCnt;
   logic             r_keyValid;
   logic [7:0]       r_toCnt;

   logic             w_inEdge;
   logic             w_ackEdge;
   logic             w_isIdle;
   logic             w_keyLoad;
   logic             w_ptLaunch;
   logic             w_dropEdge;
   logic             w_timeout;
   logic             w_ackIdle;
   logic [2:0]       w_nextState;

   assign w_inEdge   = in_valid & ~r_inValidQ;
   assign w_ackEdge  = read_ack & ~r_readAckQ;
   assign w_isIdle   = (r_state == ST_IDLE);
   assign w_keyLoad  = w_isIdle & w_inEdge & key_mode;
   assign w_ptLaunch = w_isIdle & w_inEdge & ~key_mode & r_keyValid;
   assign w_dropEdge = w_inEdge & ~w_isIdle;
   assign w_timeout  = (r_state == ST_ENCRYPT) & (r_toCnt == TO_LAST);
   assign w_ackIdle  = w_ackEdge &
                       ((r_state == ST_WAIT_READ) | (r_state == ST_ERROR));

   // Next interface state; enc_done takes priority over an expiring timeout,
   // and the reserved encoding falls back to IDLE.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_inEdge && !key_mode) begin
               if (r_keyValid) begin
                  w_nextState = ST_ENCRYPT;
               end else begin
                  w_nextState = ST_ERROR;
               end
            end
         end
         ST_ENCRYPT: begin
            if (enc_done) begin
               w_nextState = ST_WAIT_READ;
            end else if (w_timeout) begin
               w_nextState = ST_ERROR;
            end
         end
         ST_WAIT_READ: begin
            if (w_ackEdge) begin
               w_nextState = ST_IDLE;
            end
         end
         ST_ERROR: begin
            if (w_ackEdge) begin
               w_nextState = ST_IDLE;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // Previous-cycle copies of the user level strobes, kept in every state so
   // edges seen while busy are consumed rather than remembered.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_inValidQ <= 1'b0;
         r_readAckQ <= 1'b0;
      end else begin
         r_inValidQ <= in_valid;
         r_readAckQ <= read_ack;
      end
   end

   // Interface state register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Key write strobe with its index and byte, one cycle after the user edge.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_keyWe   <= 1'b0;
         r_keyIdx  <= '0;
         r_keyByte <= 8'h00;
      end else begin
         r_keyWe <= w_keyLoad;
         if (w_keyLoad) begin
            r_keyIdx  <= r_keyCnt;
            r_keyByte <= in_byte;
         end
      end
   end

   // Key byte counter wraps after a full key; the first wrap marks the key
   // usable until the next reset.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_keyCnt   <= '0;
         r_keyValid <= 1'b0;
      end else if (w_keyLoad) begin
         if (r_keyCnt == KEY_LAST) begin
            r_keyCnt   <= '0;
            r_keyValid <= 1'b1;
         end else begin
            r_keyCnt <= r_keyCnt + IDX_W'(1);
         end
      end
   end

   // Encryption launch pulse and the plaintext byte, which is held until the
   // next accepted plaintext so it stays stable throughout ENCRYPT.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_encStart <= 1'b0;
         r_encByte  <= 8'h00;
      end else begin
         r_encStart <= w_ptLaunch;
         if (w_ptLaunch) begin
            r_encByte <= in_byte;
         end
      end
   end

   // Cycles spent in ENCRYPT; cleared on launch so the expiry compare sees
   // the count of completed ENCRYPT cycles.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_toCnt <= 8'h00;
      end else if (w_ptLaunch) begin
         r_toCnt <= 8'h00;
      end else if (r_state == ST_ENCRYPT) begin
         r_toCnt <= r_toCnt + 8'h01;
      end
   end

`ifdef OVERRUN_DETECT_EN
   logic r_overrun;

   // Sticky flag for bytes dropped while busy; the acknowledge that returns
   // the interface to IDLE clears it, and wins over a same-cycle drop.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_overrun <= 1'b0;
      end else if (w_ackIdle) begin
         r_overrun <= 1'b0;
      end else if (w_dropEdge) begin
         r_overrun <= 1'b1;
      end
   end

   assign overrun = r_overrun;
   assign err     = (r_state == ST_ERROR) | r_overrun;
`else
   logic w_unusedDrop;
   assign w_unusedDrop = w_dropEdge & w_ackIdle;
   assign err          = (r_state == ST_ERROR);
`endif

   assign key_we    = r_keyWe;
   assign key_idx   = r_keyIdx;
   assign key_byte  = r_keyByte;
   assign enc_start = r_encStart;
   assign enc_byte  = r_encByte;
   assign state     = r_state;
   assign out_valid = (r_state == ST_WAIT_READ) & holder_ready;
   assign busy      = (r_state != ST_IDLE);

endmodule
